// File: rtl/sram_cycle_ctrl_if.sv
// sram_cycle_ctrl_if: request-side handshake and SRAM pin bundle for sram_cycle_ctrl.
// The optional byte-enable signal exists only when SRAM_BYTE_LANE_EN is defined.
// slave  : the cycle controller (drives strobes, address, data-out, rdata/busy/done).
// master : the requester plus the SRAM/pad side (drives requests and sram_dq_in).
interface sram_cycle_ctrl_if #(
  parameter int unsigned ADDR_W = 20
);
  // request side (MAR/MDR)
  logic              req_rd;
  logic              req_wr;
  logic [ADDR_W-1:0] addr;
  logic [15:0]       wdata;
`ifdef SRAM_BYTE_LANE_EN
  logic [1:0]        be;
`endif
  logic [15:0]       rdata;
  logic              busy;
  logic              done;

  // SRAM pin side (strobes active low)
  logic              Mem_CE;
  logic              Mem_UB;
  logic              Mem_LB;
  logic              Mem_OE;
  logic              Mem_WE;
  logic [ADDR_W-1:0] sram_addr;
  logic [15:0]       sram_dq_out;
  logic              sram_dq_oe;
  logic [15:0]       sram_dq_in;

  modport slave (
`ifdef SRAM_BYTE_LANE_EN
    input  be,
`endif
    input  req_rd, req_wr, addr, wdata, sram_dq_in,
    output rdata, busy, done,
    output Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE,
    output sram_addr, sram_dq_out, sram_dq_oe
  );

  modport master (
`ifdef SRAM_BYTE_LANE_EN
    output be,
`endif
    output req_rd, req_wr, addr, wdata, sram_dq_in,
    input  rdata, busy, done,
    input  Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE,
    input  sram_addr, sram_dq_out, sram_dq_oe
  );
endinterface

// File: rtl/sram_cycle_ctrl.sv
// sram_cycle_ctrl: turns single-cycle read/write requests from the LC-3 control
// FSM into wait-stated bus cycles on an async 16-bit SRAM, returning a registered
// read word and a one-cycle done pulse.
// Optional feature macro: SRAM_BYTE_LANE_EN (adds per-lane write enables via be).
// Every pin is a flop: the output decode is computed from the next state, so the
// registered strobes always line up with the state they belong to.
module sram_cycle_ctrl #(
  parameter int unsigned ADDR_W  = 20,
  parameter int unsigned RD_WAIT = 2,
  parameter int unsigned WR_WAIT = 2
) (
  input logic               Clk,
  input logic               Reset,
  sram_cycle_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ACT,
    S_WR_SETUP,
    S_WR_ACT,
    S_WR_HOLD,
    S_FIN
  } state_t;

  localparam logic [3:0] RD_LAST = 4'(RD_WAIT - 1);
  localparam logic [3:0] WR_LAST = 4'(WR_WAIT - 1);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       dq_out_q, dq_out_d;
  logic [15:0]       rdata_q, rdata_d;
  logic              ce_q, ce_d;
  logic              ub_q, ub_d;
  logic              lb_q, lb_d;
  logic              oe_q, oe_d;
  logic              we_q, we_d;
  logic              dq_oe_q, dq_oe_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
`ifdef SRAM_BYTE_LANE_EN
  logic [1:0]        be_q, be_d;
`endif

  // Next-state, request capture and read-data sampling.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    dq_out_d = dq_out_q;
    rdata_d  = rdata_q;
`ifdef SRAM_BYTE_LANE_EN
    be_d     = be_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        // write wins over a simultaneous read; the read is simply dropped
        if (bus.req_wr) begin
          state_d  = S_WR_SETUP;
          addr_d   = bus.addr;
          dq_out_d = bus.wdata;
          cnt_d    = '0;
`ifdef SRAM_BYTE_LANE_EN
          be_d     = bus.be;
`endif
        end else if (bus.req_rd) begin
          state_d = S_RD_ACT;
          addr_d  = bus.addr;
          cnt_d   = '0;
        end
      end
      S_RD_ACT: begin
        if (cnt_q == RD_LAST) begin
          rdata_d = bus.sram_dq_in;
          cnt_d   = '0;
          state_d = S_FIN;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_WR_SETUP: begin
        cnt_d   = '0;
        state_d = S_WR_ACT;
      end
      S_WR_ACT: begin
        if (cnt_q == WR_LAST) begin
          cnt_d   = '0;
          state_d = S_WR_HOLD;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_WR_HOLD: state_d = S_FIN;
      S_FIN:     state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Pin decode for the state being entered; registered below.
  always_comb begin
    ce_d    = 1'b1;
    oe_d    = 1'b1;
    we_d    = 1'b1;
    dq_oe_d = 1'b0;
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_FIN);
    unique case (state_d)
      S_RD_ACT: begin
        ce_d = 1'b0;
        oe_d = 1'b0;
      end
      S_WR_SETUP: begin
        ce_d    = 1'b0;
        dq_oe_d = 1'b1;
      end
      S_WR_ACT: begin
        ce_d    = 1'b0;
        we_d    = 1'b0;
        dq_oe_d = 1'b1;
      end
      S_WR_HOLD: begin
        ce_d    = 1'b0;
        dq_oe_d = 1'b1;
      end
      default: ;
    endcase
`ifdef SRAM_BYTE_LANE_EN
    // write states drive the captured lane enables; reads assert both lanes
    if (dq_oe_d) begin
      ub_d = ~be_d[1];
      lb_d = ~be_d[0];
    end else begin
      ub_d = ce_d;
      lb_d = ce_d;
    end
`else
    ub_d = ce_d;
    lb_d = ce_d;
`endif
  end

  // State, counter and captured request registers.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      dq_out_q <= '0;
      rdata_q  <= '0;
`ifdef SRAM_BYTE_LANE_EN
      be_q     <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      dq_out_q <= dq_out_d;
      rdata_q  <= rdata_d;
`ifdef SRAM_BYTE_LANE_EN
      be_q     <= be_d;
`endif
    end
  end

  // Registered pin and status outputs; reset forces every strobe inactive.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      ce_q    <= 1'b1;
      ub_q    <= 1'b1;
      lb_q    <= 1'b1;
      oe_q    <= 1'b1;
      we_q    <= 1'b1;
      dq_oe_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      ce_q    <= ce_d;
      ub_q    <= ub_d;
      lb_q    <= lb_d;
      oe_q    <= oe_d;
      we_q    <= we_d;
      dq_oe_q <= dq_oe_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.Mem_CE      = ce_q;
  assign bus.Mem_UB      = ub_q;
  assign bus.Mem_LB      = lb_q;
  assign bus.Mem_OE      = oe_q;
  assign bus.Mem_WE      = we_q;
  assign bus.sram_dq_oe  = dq_oe_q;
  assign bus.sram_addr   = addr_q;
  assign bus.sram_dq_out = dq_out_q;
  assign bus.rdata       = rdata_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;

  // Bus contention guards: output enable never overlaps a write strobe or pad drive.
  a_oe_we_excl: assert property (@(posedge Clk) disable iff (Reset) !(!oe_q && !we_q));
  a_oe_pad_excl: assert property (@(posedge Clk) disable iff (Reset) !(!oe_q && dq_oe_q));

endmodule

// File: tb/tb_sram_cycle_ctrl.sv
// tb_sram_cycle_ctrl: randomized bench for sram_cycle_ctrl with a behavioural
// SRAM and a word-level reference memory. Build with SRAM_BYTE_LANE_EN defined
// to exercise the byte-lane variant.
module tb_sram_cycle_ctrl;
  localparam int unsigned AW  = 20;
  localparam int unsigned RDW = 2;
  localparam int unsigned WRW = 2;

  logic clk = 1'b0;
  logic rst;

  sram_cycle_ctrl_if #(.ADDR_W(AW)) bus ();

  sram_cycle_ctrl #(.ADDR_W(AW), .RD_WAIT(RDW), .WR_WAIT(WRW)) dut (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] init_word(input int unsigned i);
    init_word = 16'((i * 40503) ^ 23130);
  endfunction

  // Behavioural 1K-word SRAM (address aliased on the low 10 bits).
  // Writes land while CE and WE are both low; each lane gated by its strobe.
  logic [15:0] sram_mem [0:1023];
  logic        pl_en;
  logic [9:0]  pl_idx;
  logic [15:0] pl_data;

  initial begin
    for (int i = 0; i < 1024; i++) sram_mem[i] = init_word(i);
    forever begin
      @(negedge clk);
      if (pl_en) begin
        sram_mem[pl_idx] = pl_data;
      end else if (!bus.Mem_CE && !bus.Mem_WE) begin
        if (!bus.Mem_UB) sram_mem[bus.sram_addr[9:0]][15:8] = bus.sram_dq_out[15:8];
        if (!bus.Mem_LB) sram_mem[bus.sram_addr[9:0]][7:0]  = bus.sram_dq_out[7:0];
      end
    end
  end

  assign bus.sram_dq_in = (!bus.Mem_CE && !bus.Mem_OE) ? sram_mem[bus.sram_addr[9:0]] : 16'h0000;

  // Reference: expected memory contents and expected last read word.
  logic [15:0] exp_mem [0:1023];
  logic [15:0] exp_rdata;

  task automatic preload(input logic [9:0] ix, input logic [15:0] d);
    pl_idx  = ix;
    pl_data = d;
    pl_en   = 1'b1;
    @(negedge clk);
    pl_en   = 1'b0;
    exp_mem[ix] = d;
  endtask

  task automatic drive_be(input logic [1:0] be);
`ifdef SRAM_BYTE_LANE_EN
    bus.be = be;
`else
    if (be == 2'b00) bus.wdata = bus.wdata;
`endif
  endtask

  // One bus transaction, called on a negedge with the DUT in IDLE or FIN.
  // Returns on the negedge where done is observed (the FIN cycle).
  task automatic run_txn(input bit wr, input bit rd, input logic [AW-1:0] a,
                         input logic [15:0] d, input logic [1:0] be, input bit hold);
    int unsigned lat, n_oe, n_we, n_dq, both, oedq, lane_bad, busy_bad, exp_lat;
    bit          seen;
    logic [9:0]  ix;
    logic [1:0]  be_eff;
    ix = a[9:0];
`ifdef SRAM_BYTE_LANE_EN
    be_eff = be;
`else
    be_eff = 2'b11;
`endif
    bus.req_wr = wr;
    bus.req_rd = rd;
    bus.addr   = a;
    bus.wdata  = d;
    drive_be(be);
    if (bus.busy) @(negedge clk);
    check_eq("idle_busy", 32'(bus.busy), 0);
    check_eq("idle_done", 32'(bus.done), 0);
    lat = 0; n_oe = 0; n_we = 0; n_dq = 0; both = 0; oedq = 0; lane_bad = 0; busy_bad = 0;
    seen = 1'b0;
    while (!seen && lat < 40) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        if (!hold) begin
          bus.req_wr = 1'b0;
          bus.req_rd = 1'b0;
        end
        bus.addr  = AW'($urandom);
        bus.wdata = 16'($urandom);
        drive_be(2'($urandom));
      end
      if (!bus.Mem_OE) n_oe++;
      if (!bus.Mem_WE) n_we++;
      if (bus.sram_dq_oe) n_dq++;
      if (!bus.Mem_OE && !bus.Mem_WE) both++;
      if (!bus.Mem_OE && bus.sram_dq_oe) oedq++;
      if (!bus.Mem_CE) begin
        if ((wr && bus.sram_dq_oe) ? ({bus.Mem_UB, bus.Mem_LB} != ~be_eff)
                                   : ({bus.Mem_UB, bus.Mem_LB} != 2'b00)) lane_bad++;
      end else if ({bus.Mem_UB, bus.Mem_LB} != 2'b11) begin
        lane_bad++;
      end
      if (bus.done) seen = 1'b1;
      else if (!bus.busy) busy_bad++;
    end
    exp_lat = wr ? WRW + 3 : RDW + 1;
    check_eq("done_seen", 32'(seen), 1);
    check_eq("latency", lat, exp_lat);
    check_eq("oe_low_cycles", n_oe, wr ? 0 : RDW);
    check_eq("we_low_cycles", n_we, wr ? WRW : 0);
    check_eq("dq_oe_cycles", n_dq, wr ? WRW + 2 : 0);
    check_eq("oe_we_overlap", both, 0);
    check_eq("oe_pad_overlap", oedq, 0);
    check_eq("lane_strobes", lane_bad, 0);
    check_eq("busy_in_cycle", busy_bad, 0);
    check_eq("fin_pins", 32'({bus.Mem_CE, bus.Mem_UB, bus.Mem_LB, bus.Mem_OE, bus.Mem_WE, bus.sram_dq_oe}), 32'h3E);
    check_eq("sram_addr", 32'(bus.sram_addr), 32'(a));
    if (wr) begin
      if (be_eff[1]) exp_mem[ix][15:8] = d[15:8];
      if (be_eff[0]) exp_mem[ix][7:0]  = d[7:0];
      check_eq("dq_out", 32'(bus.sram_dq_out), 32'(d));
      check_eq("mem_word", 32'(sram_mem[ix]), 32'(exp_mem[ix]));
    end else begin
      exp_rdata = exp_mem[ix];
    end
    check_eq("rdata", 32'(bus.rdata), 32'(exp_rdata));
  endtask

  task automatic reset_mid_write();
    int unsigned guard;
    bus.req_wr = 1'b1;
    bus.req_rd = 1'b0;
    bus.addr   = 20'h003FF;
    bus.wdata  = 16'hC3C3;
    drive_be(2'b11);
    guard = 0;
    while (bus.Mem_WE && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    check_eq("reach_wr_act", 32'(bus.Mem_WE), 0);
    bus.req_wr = 1'b0;
    // the model has committed the word on this negedge (WE low); account for it
    exp_mem[10'h3FF] = 16'hC3C3;
    #2 rst = 1'b1;
    #1;
    check_eq("rst_we", 32'(bus.Mem_WE), 1);
    check_eq("rst_dq_oe", 32'(bus.sram_dq_oe), 0);
    check_eq("rst_ce", 32'(bus.Mem_CE), 1);
    check_eq("rst_busy", 32'(bus.busy), 0);
    check_eq("rst_done", 32'(bus.done), 0);
    exp_rdata = 16'h0000;
    check_eq("rst_rdata", 32'(bus.rdata), 0);
    check_eq("rst_addr", 32'(bus.sram_addr), 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check_eq("post_rst_done", 32'(bus.done), 0);
      check_eq("post_rst_busy", 32'(bus.busy), 0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit prev_hold;
    int unsigned kind;
    rst        = 1'b1;
    pl_en      = 1'b0;
    pl_idx     = '0;
    pl_data    = '0;
    bus.req_rd = 1'b0;
    bus.req_wr = 1'b0;
    bus.addr   = '0;
    bus.wdata  = '0;
    drive_be(2'b11);
    for (int i = 0; i < 1024; i++) exp_mem[i] = init_word(i);
    exp_rdata = 16'h0000;

    repeat (3) @(negedge clk);
    check_eq("reset_strobes", 32'({bus.Mem_CE, bus.Mem_UB, bus.Mem_LB, bus.Mem_OE, bus.Mem_WE}), 32'h1F);
    check_eq("reset_dq_oe", 32'(bus.sram_dq_oe), 0);
    check_eq("reset_busy", 32'(bus.busy), 0);
    check_eq("reset_done", 32'(bus.done), 0);
    check_eq("reset_rdata", 32'(bus.rdata), 0);
    check_eq("reset_addr", 32'(bus.sram_addr), 0);
    check_eq("reset_dq_out", 32'(bus.sram_dq_out), 0);
    rst = 1'b0;
    @(negedge clk);

    // directed cases
    preload(10'h123, 16'hBEEF);
    run_txn(1'b0, 1'b1, 20'h00123, 16'h0000, 2'b11, 1'b0);
    check_eq("read_beef", 32'(bus.rdata), 32'hBEEF);
    run_txn(1'b1, 1'b0, 20'h00040, 16'h1234, 2'b11, 1'b0);
    check_eq("write_1234", 32'(sram_mem[10'h040]), 32'h1234);
    run_txn(1'b1, 1'b1, 20'h00055, 16'h6E6E, 2'b11, 1'b0);
    run_txn(1'b1, 1'b0, 20'h00007, 16'hA5A5, 2'b11, 1'b1);
    run_txn(1'b0, 1'b1, 20'h00007, 16'h0000, 2'b11, 1'b0);
    check_eq("b2b_rdata", 32'(bus.rdata), 32'hA5A5);
`ifdef SRAM_BYTE_LANE_EN
    preload(10'h009, 16'h1357);
    run_txn(1'b1, 1'b0, 20'h00009, 16'hFF00, 2'b10, 1'b0);
    check_eq("be10_word", 32'(sram_mem[10'h009]), 32'hFF57);
    run_txn(1'b1, 1'b0, 20'h00009, 16'h0000, 2'b00, 1'b0);
    check_eq("be00_word", 32'(sram_mem[10'h009]), 32'hFF57);
`endif
    @(negedge clk);
    reset_mid_write();

    // randomized traffic
    prev_hold = 1'b0;
    for (int t = 0; t < 200; t++) begin
      bit          h;
      logic [AW-1:0] a;
      kind = $urandom_range(0, 4);
      h    = ($urandom_range(0, 3) == 0);
      a    = AW'($urandom);
      if (!prev_hold) begin
        int unsigned gap;
        gap = $urandom_range(0, 2);
        for (int g = 0; g < int'(gap); g++) begin
          @(negedge clk);
          check_eq("idle_gap", 32'(bus.busy), 0);
        end
      end
      run_txn(kind >= 2, (kind == 0) || (kind == 1) || (kind == 4), a,
              16'($urandom), 2'($urandom), h);
      prev_hold = h;
    end
    bus.req_wr = 1'b0;
    bus.req_rd = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("final_idle", 32'(bus.busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sram_cycle_ctrl.md
Name: sram_cycle_ctrl

Overview:
- Downstream of the LC-3 control-unit FSM.
- Converts single-cycle read/write requests (derived from MAR/MDR load states) into timed, wait-stated SRAM bus cycles on the board's async 16-bit SRAM.
- Returns a registered read word and a one-cycle done pulse, so the FSM needs one wait state instead of a fixed cycle count.
- Sits between the MAR/MDR registers and the SRAM pins.

Parameters:
- ADDR_W, 20, SRAM address width.
- RD_WAIT, 2, cycles OE_N held low before data is sampled (legal range 1..15).
- WR_WAIT, 2, cycles WE_N held low (legal range 1..15).

Ports:
- Clk  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-high reset.
- req_rd  in  1  read request, sampled only in IDLE.
- req_wr  in  1  write request, sampled only in IDLE.
- addr  in  ADDR_W  request address (MAR), captured on acceptance.
- wdata  in  16  write data (MDR), captured on acceptance.
- rdata  out  16  last read word, registered; holds until the next read completes.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when a cycle completes.
- Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE  out  1 each  active-low SRAM strobes.
- sram_addr  out  ADDR_W  registered SRAM address.
- sram_dq_out  out  16  write data to the pad driver.
- sram_dq_oe  out  1  pad tristate enable; high only while driving a write.
- sram_dq_in  in  16  data from the SRAM pads.

Behaviour:
- Reset (async, any state):
  - State goes to IDLE; wait counter = 0.
  - All strobes = 1; sram_dq_oe = 0; busy = 0; done = 0; rdata = 0; sram_addr = 0; sram_dq_out = 0.
  - A cycle in flight is abandoned, with no done pulse.
- All outputs are registered. No combinational path from req_* to the pins.
- States and transitions:
  - IDLE: if req_wr, latch addr/wdata and go to WR_SETUP; else if req_rd, latch addr and go to RD_ACT.
    - req_wr has priority when both are high. The read is dropped, not queued.
  - RD_ACT: Mem_CE = 0, Mem_OE = 0, UB/LB = 0. Counter counts 0..RD_WAIT-1. On the last count, sample sram_dq_in into rdata and go to FIN.
  - WR_SETUP: one cycle. Mem_CE = 0, sram_dq_oe = 1, Mem_WE = 1 (address/data setup).
  - WR_ACT: Mem_WE = 0, sram_dq_oe = 1 for WR_WAIT cycles, then go to WR_HOLD.
  - WR_HOLD: one cycle. Mem_WE = 1, sram_dq_oe still 1 (data hold). Then go to FIN.
  - FIN: done = 1 for exactly this cycle; all strobes = 1; go to IDLE.
- Latency, request accepted to done high:
  - Read: RD_WAIT + 1 cycles.
  - Write: WR_WAIT + 3 cycles.
- Back-to-back: a request held high through FIN is accepted in the following IDLE cycle. Minimum one idle cycle between bus cycles.
- Mem_OE and Mem_WE are never low in the same cycle. Mem_OE is never low while sram_dq_oe = 1.
- req_*, addr and wdata are ignored while busy. Changing them mid-cycle has no effect on the cycle in progress.
- rdata updates only at the RD_ACT exit sample. Writes never change rdata.

Optional Feature:
- Macro: SRAM_BYTE_LANE_EN.
- When defined:
  - Adds input be[1:0], captured with a write request.
  - During WR_SETUP/WR_ACT/WR_HOLD, Mem_UB = ~be[1] and Mem_LB = ~be[0].
  - be = 00 completes as a normal write cycle with done, and neither lane is written.
  - Reads always assert both lanes.
- When not defined: no be port; Mem_UB = Mem_LB = 0 whenever Mem_CE = 0.

Test Plan:
- Reset mid-write:
  - Stimulus: assert Reset asynchronously during WR_ACT.
  - Response: Mem_WE = 1 and sram_dq_oe = 0 before the next edge; state IDLE; no done pulse.
- Read, RD_WAIT=2:
  - Stimulus: req_rd with addr=0x00123; model returns 0xBEEF.
  - Response: Mem_OE low for exactly 2 cycles; done high 3 cycles after acceptance; rdata = 0xBEEF; sram_addr = 0x00123.
- Write, WR_WAIT=2:
  - Stimulus: req_wr with addr=0x00040, wdata=0x1234.
  - Response: Mem_WE low for 2 cycles inside an sram_dq_oe window of 4 cycles; done 5 cycles after acceptance; model memory[0x40] = 0x1234; rdata unchanged.
- Simultaneous requests:
  - Stimulus: req_rd and req_wr both high in IDLE.
  - Response: write performed; no read cycle; Mem_OE stays 1 throughout.
- Back-to-back:
  - Stimulus: write 0xA5A5 to 0x7, then read 0x7, with requests held high.
  - Response: read starts the cycle after FIN; rdata = 0xA5A5; Mem_OE and Mem_WE never both low.
- Byte lanes (SRAM_BYTE_LANE_EN defined):
  - Stimulus: write 0xFF00 with be=10.
  - Response: Mem_UB = 0, Mem_LB = 1 during the write; the model updates only the high byte.
